uart_tx_frame_ctrl: RTL and testbench
=====================================

Name: uart_tx_frame_ctrl

Overview:
UART transmit frame controller that sits directly upstream of the TX serializer and drives the serial line. It accepts a parallel byte from the system side with a valid strobe and latches the byte and the parity configuration. It loads the serializer and sequences the start, data, parity and stop bits onto TX_OUT. Its inputs are the serializer's bit stream and done flag, and it cross-checks the serializer's bit count against its own counter.

Parameters:
DATA_WIDTH, 8, data bits per frame; the serializer handshake and bit counter are sized to it
CNT_W, 4, bit counter width; must hold DATA_WIDTH

Ports:
CLK  in  1  system clock; every register updates on the rising edge
RST  in  1  synchronous, active-high reset
P_DATA  in  DATA_WIDTH  byte to transmit
Data_Valid  in  1  request strobe; sampled only when the block can accept
PAR_EN  in  1  1 = append a parity bit
PAR_TYP  in  1  0 = even parity, 1 = odd parity
ser_data  in  1  current serial bit from the serializer, LSB first
ser_done  in  1  serializer flag; high in the cycle it presents its last data bit
ser_load  out  1  one-cycle pulse; the serializer captures ser_pdata
ser_pdata  out  DATA_WIDTH  latched frame data for the serializer
ser_en  out  1  high for every DATA-state cycle; the serializer advances one bit per cycle
TX_OUT  out  1  serial line, idle high
Busy  out  1  frame in progress; new requests are ignored while high
seq_err  out  1  sticky flag for a serializer bit-count mismatch

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. State register, bit counter, latched data, parity bit and config flags are all registered.
- Reset (RST=1 at an edge): the next state is IDLE regardless of current state, including mid-frame. Reset values: TX_OUT=1, Busy=0, ser_en=0, ser_load=0, ser_pdata=0, seq_err=0, counter=0.
- Accept condition: state is IDLE or STOP, and Data_Valid=1. Data_Valid in any other state is dropped with no effect.
- On accept, in the same edge:
  - latch P_DATA into ser_pdata;
  - latch PAR_EN and PAR_TYP;
  - compute parity = (^P_DATA) XOR PAR_TYP;
  - move to START.
- START, 1 cycle: TX_OUT=0, Busy=1, ser_load=1 (only in this cycle), counter cleared. Next state is DATA.
- DATA, exactly DATA_WIDTH cycles:
  - ser_en=1, Busy=1, TX_OUT=ser_data (combinational pass-through).
  - counter increments every cycle.
  - Exit after the cycle in which counter == DATA_WIDTH-1: to PARITY if the latched PAR_EN=1, otherwise to STOP.
- seq_err is set in either case:
  - ser_done=1 in a DATA cycle with counter != DATA_WIDTH-1;
  - ser_done=0 in the final DATA cycle.
  The frame still completes on the internal counter. seq_err is cleared only by RST.
- PARITY, 1 cycle: TX_OUT = latched parity bit, Busy=1, ser_en=0.
- STOP, 1 cycle: TX_OUT=1, Busy=0. If Data_Valid=1, go to START (back-to-back frames with no idle bit); otherwise go to IDLE.
- IDLE: TX_OUT=1, Busy=0, ser_en=0.
- Frame length from the START cycle through the STOP cycle: 1+DATA_WIDTH+PAR_EN+1 cycles. At the default width this is 11 cycles with parity and 10 without.
- Latency: Data_Valid is sampled at edge T; the START bit appears on TX_OUT in cycle T+1.
- PAR_EN, PAR_TYP or P_DATA changing mid-frame has no effect on the current frame.

Test Plan:
- The bench uses a behavioural serializer per the port contract: it loads on ser_load and shifts LSB first on ser_en.
- Even parity, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one Data_Valid pulse -> TX_OUT over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1; Busy high for 10 cycles; seq_err=0.
- Odd parity, 0xA5, PAR_TYP=1 -> parity bit = 1; parity disabled (PAR_EN=0) -> 10-cycle frame, line 0,1,0,1,0,0,1,0,1,1.
- Back-to-back: 0x3C then 0xFF, with Data_Valid held high through the STOP cycle of the first frame -> the second START immediately follows the first STOP with no idle gap. Second frame line (even parity) = 0,1,1,1,1,1,1,1,1,0,1.
- Data_Valid pulsed with 0x55 during DATA of a 0x0F frame -> 0x0F frame transmitted unchanged; 0x55 never sent; the line returns to IDLE high.
- Serializer model asserts ser_done after 7 bits -> seq_err=1; the frame still ends after 8 data bits; seq_err stays 1 across later frames until RST.
- RST asserted on the 4th DATA cycle -> TX_OUT=1, Busy=0, ser_en=0 on the next cycle; a fresh 0xA5 request afterwards produces a correct frame.

Source files
------------

// File: rtl/uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_ctrl
//
// UART transmit frame controller. Accepts a parallel word from the system side,
// latches it together with the parity configuration, loads the downstream bit
// serializer and sequences START / DATA / PARITY / STOP onto the serial line.
// During DATA the line is a straight combinational pass-through of the
// serializer's current bit. The serializer's "last bit" flag is cross-checked
// against the internal bit counter; any disagreement raises a sticky error.
//
// Ports
//   CLK         system clock, all registers update on the rising edge
//   RST         synchronous, active-high reset
//   P_DATA      word to transmit
//   Data_Valid  request strobe, honoured only in IDLE or STOP
//   PAR_EN      1 = append a parity bit to the frame
//   PAR_TYP     0 = even parity, 1 = odd parity
//   ser_data    current serial bit from the serializer (LSB first)
//   ser_done    serializer flag, high while it presents its last data bit
//   ser_load    one-cycle pulse (START cycle), serializer captures ser_pdata
//   ser_pdata   latched frame data for the serializer
//   ser_en      high in every DATA cycle, serializer advances one bit per cycle
//   TX_OUT      serial line, idle high
//   Busy        frame in progress (START, DATA, PARITY)
//   seq_err     sticky serializer bit-count mismatch flag, cleared only by RST
// -----------------------------------------------------------------------------
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_load,
    output logic [DATA_WIDTH-1:0] ser_pdata,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  seq_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [2:0]            state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] pdata_q,   pdata_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_en_q,  par_en_d;
    logic                  seq_err_q, seq_err_d;

    logic accept;
    logic last_bit;

    // A new request is taken in IDLE and also in STOP, which lets frames run
    // back to back with no idle bit between the stop bit and the next start.
    assign accept   = ((state_q == IDLE) || (state_q == STOP)) && Data_Valid;
    assign last_bit = (cnt_q == LAST_CNT);

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pdata_d   = pdata_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        seq_err_d = seq_err_q;

        if (accept) begin
            // Everything the frame needs is captured here, so later changes on
            // P_DATA / PAR_EN / PAR_TYP cannot disturb the frame in flight.
            pdata_d   = P_DATA;
            par_en_d  = PAR_EN;
            par_bit_d = (^P_DATA) ^ PAR_TYP;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                // The serializer must flag done exactly on the final bit; an
                // early flag or a missing one both count as a sequencing error.
                // The frame itself always finishes on the internal counter.
                if (ser_done != last_bit) begin
                    seq_err_d = 1'b1;
                end
                if (last_bit) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                state_d = accept ? START : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pdata_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pdata_q   <= pdata_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            seq_err_q <= seq_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from the registered state
    // -------------------------------------------------------------------------
    always_comb begin
        TX_OUT   = 1'b1;
        Busy     = 1'b0;
        ser_en   = 1'b0;
        ser_load = 1'b0;
        case (state_q)
            START: begin
                TX_OUT   = 1'b0;
                Busy     = 1'b1;
                ser_load = 1'b1;
            end
            DATA: begin
                TX_OUT = ser_data;
                Busy   = 1'b1;
                ser_en = 1'b1;
            end
            PARITY: begin
                TX_OUT = par_bit_q;
                Busy   = 1'b1;
            end
            default: begin
                TX_OUT = 1'b1;
            end
        endcase
    end

    assign ser_pdata = pdata_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame_ctrl
//
// Scoreboard bench: each request pushes its hand-computed line sequence; a
// monitor process pops a frame when the DUT pulses ser_load and compares the
// line, Busy, ser_en and ser_load cycle by cycle. A behavioural serializer
// loads on ser_load and shifts LSB first on ser_en.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame_ctrl;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          ser_data;
    logic          ser_done;
    logic          ser_load;
    logic [DW-1:0] ser_pdata;
    logic          ser_en;
    logic          TX_OUT;
    logic          Busy;
    logic          seq_err;

    uart_tx_frame_ctrl #(.DATA_WIDTH(DW), .CNT_W(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_load   (ser_load),
        .ser_pdata  (ser_pdata),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .seq_err    (seq_err)
    );

    always #5 CLK = ~CLK;

    // Behavioural serializer
    logic [DW-1:0] sreg = '0;
    int            scnt = 0;
    logic          bad_done = 1'b0;   // flag done one bit early

    always @(posedge CLK) begin
        if (ser_load) begin
            sreg <= ser_pdata;
            scnt <= 0;
        end else if (ser_en) begin
            sreg <= sreg >> 1;
            scnt <= scnt + 1;
        end
    end

    assign ser_data = sreg[0];
    assign ser_done = bad_done ? (scnt == DW - 2) : (scnt == DW - 1);

    // Scoreboard
    typedef struct {
        logic [0:10]   line;    // expected TX_OUT, first cycle leftmost
        int            len;
        logic [DW-1:0] data;
        logic          follow;  // next frame must start right after STOP
    } frame_t;

    frame_t sb_q[$];
    int     checks = 0;
    int     errors = 0;
    logic   mon_active = 1'b0;
    logic   expect_load = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [0:10] line, input int len,
                              input logic [DW-1:0] data, input logic follow);
        frame_t f;
        f.line   = line;
        f.len    = len;
        f.data   = data;
        f.follow = follow;
        sb_q.push_back(f);
    endtask

    task automatic monitor_loop();
        frame_t cur;
        int     idx;
        cur.line = '0; cur.len = 0; cur.data = '0; cur.follow = 1'b0;
        idx = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                mon_active  = 1'b0;
                expect_load = 1'b0;
            end else begin
                if (expect_load) begin
                    chk("b2b_no_gap", ser_load, 1);
                    expect_load = 1'b0;
                end
                if (ser_load && !mon_active) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got data %0h, expected no frame (t=%0t)",
                                 ser_pdata, $time);
                    end else begin
                        cur = sb_q.pop_front();
                        chk("ser_pdata", ser_pdata, cur.data);
                        mon_active = 1'b1;
                        idx = 0;
                    end
                end
                if (mon_active) begin
                    chk($sformatf("tx_%02h_bit%0d", cur.data, idx), TX_OUT, cur.line[idx]);
                    chk($sformatf("busy_%02h_bit%0d", cur.data, idx), Busy, idx != cur.len - 1);
                    chk($sformatf("ser_en_%02h_bit%0d", cur.data, idx), ser_en,
                        (idx >= 1) && (idx <= DW));
                    chk($sformatf("ser_load_%02h_bit%0d", cur.data, idx), ser_load, idx == 0);
                    idx++;
                    if (idx == cur.len) begin
                        mon_active  = 1'b0;
                        expect_load = cur.follow;
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || mon_active || Busy) && n < 40) begin
            @(posedge CLK); #2;
            n++;
        end
        chk({name, "_complete"}, (sb_q.size() == 0) && !mon_active && !Busy, 1);
        @(posedge CLK); #2;
        chk({name, "_idle_tx"}, TX_OUT, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST        = 1'b1;
        P_DATA     = '0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        chk("rst_tx", TX_OUT, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_ser_en", ser_en, 0);
        chk("rst_ser_load", ser_load, 0);
        chk("rst_ser_pdata", ser_pdata, 0);
        chk("rst_seq_err", seq_err, 0);

        // Even parity 0xA5
        push_frame(11'b0_10100101_0_1, 11, 8'hA5, 1'b0);
        send(8'hA5, 1'b1, 1'b0);
        wait_idle("even_a5");
        chk("even_a5_seq_err", seq_err, 0);

        // Odd parity 0xA5
        push_frame(11'b0_10100101_1_1, 11, 8'hA5, 1'b0);
        send(8'hA5, 1'b1, 1'b1);
        wait_idle("odd_a5");

        // No parity 0xA5 (10-cycle frame)
        push_frame(11'b0_10100101_1_1, 10, 8'hA5, 1'b0);
        send(8'hA5, 1'b0, 1'b0);
        wait_idle("nopar_a5");

        // Back-to-back 0x3C then 0xFF, Data_Valid held through first STOP
        push_frame(11'b0_00111100_0_1, 11, 8'h3C, 1'b1);
        push_frame(11'b0_11111111_0_1, 11, 8'hFF, 1'b0);
        P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        @(posedge CLK); #1;
        P_DATA = 8'hFF;
        repeat (11) @(posedge CLK);
        #1 Data_Valid = 1'b0;
        wait_idle("b2b");

        // Request during DATA is dropped
        push_frame(11'b0_11110000_0_1, 11, 8'h0F, 1'b0);
        send(8'h0F, 1'b1, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
        wait_idle("drop_55");
        repeat (3) @(posedge CLK);
        #2 chk("drop_55_still_idle", Busy, 0);

        // Serializer flags done early: sticky error, frame length unchanged
        bad_done = 1'b1;
        push_frame(11'b0_10100101_0_1, 11, 8'hA5, 1'b0);
        send(8'hA5, 1'b1, 1'b0);
        wait_idle("early_done");
        chk("early_done_seq_err", seq_err, 1);
        bad_done = 1'b0;
        push_frame(11'b0_11111111_1_1, 10, 8'hFF, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        wait_idle("after_err");
        chk("seq_err_sticky", seq_err, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        #1 chk("seq_err_cleared", seq_err, 0);

        // Reset during the 4th DATA cycle
        push_frame(11'b0_10100101_0_1, 11, 8'hA5, 1'b0);
        send(8'hA5, 1'b1, 1'b0);
        repeat (4) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        chk("midrst_tx", TX_OUT, 1);
        chk("midrst_busy", Busy, 0);
        chk("midrst_ser_en", ser_en, 0);
        chk("midrst_sb_empty", sb_q.size(), 0);
        push_frame(11'b0_10100101_0_1, 11, 8'hA5, 1'b0);
        send(8'hA5, 1'b1, 1'b0);
        wait_idle("post_rst_a5");
        chk("post_rst_seq_err", seq_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
